afe_spi_reg_ctrl: RTL and testbench

Register-transaction sequencer sitting directly upstream of the AFE4403 SPI byte engine. Accepts one register write or read request (8-bit address, 24-bit data) and drives the engine's wr_en/rd_en/stage_rst/flag/tx_data, consuming spi_done/rx_data. Handles AFE4403 byte framing (address byte plus 3 data bytes, MSB first) and read mode. For reads, the read-enable wrap is CONTROL0 = 0x000001 before the read and CONTROL0 = 0x000000 after it.

---
 rtl/afe_spi_pkg.sv | 24 ++
 rtl/afe_spi_reg_ctrl.sv | 149 ++++++++++++++
 tb/tb_afe_spi_reg_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afe_spi_pkg.sv
// rtl/afe_spi_pkg.sv - shared types and AFE4403 framing constants for the SPI register sequencer
package afe_spi_pkg;

  typedef enum logic [2:0] {IDLE, PREP, WR_BYTES, TURN, RD_BYTES, GAP, DONE} state_e;
  typedef enum logic [1:0] {FR_A, FR_R, FR_W, FR_C} frame_e;

  localparam logic [7:0]  CONTROL0 = 8'h00;
  localparam logic [23:0] SPI_READ = 24'h000001;
  localparam int          BYTE_CYC = 16;

  // Byte idx (0 = first on the wire) of a frame; read frames carry only the address byte.
  function automatic logic [7:0] frame_byte(input frame_e f, input logic [7:0] addr,
                                            input logic [23:0] wdata, input logic [1:0] idx);
    logic [31:0] word;
    case (f)
      FR_A:    word = {CONTROL0, SPI_READ};
      FR_C:    word = {CONTROL0, 24'h000000};
      FR_W:    word = {addr, wdata};
      default: word = {addr, 24'h000000};
    endcase
    return word[8*(3-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/afe_spi_reg_ctrl.sv
// rtl/afe_spi_reg_ctrl.sv - register write/read sequencer driving the AFE4403 SPI byte engine
module afe_spi_reg_ctrl
  import afe_spi_pkg::*;
#(
  parameter int GAP_CYC   = 4,
  parameter int TURN_CYC  = 1,
  parameter int WDOG_CYC  = 32,
  parameter bit READ_WRAP = 1'b1
) (
  input  logic        div_clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [23:0] wdata,
  input  logic        abort,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [23:0] rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic        stage_rst,
  output logic        flag,
  output logic [7:0]  tx_data,
  input  logic        spi_done,
  input  logic [7:0]  rx_data
);

  state_e      state, state_nxt;
  frame_e      frame, frame_nxt;
  logic [7:0]  addr_q;
  logic [23:0] wdata_q;
  logic [1:0]  byte_idx;
  logic [7:0]  cnt;
  logic [15:0] acc;
  logic        wdog_q;
  logic        in_byte, byte_done, wdog_exp, last_wr;

  assign in_byte   = (state == WR_BYTES) || (state == RD_BYTES);
  assign byte_done = in_byte && spi_done;
  assign wdog_exp  = in_byte && !spi_done && (cnt == 8'(WDOG_CYC - 1));
  assign last_wr   = (frame == FR_R) ? (byte_idx == 2'd0) : (byte_idx == 2'd3);

  assign busy = (state != IDLE);
  assign ack  = (state == DONE) && !abort;
  assign err  = ack && wdog_q;

  always_comb begin
    state_nxt = state;
    frame_nxt = frame;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    flag      = 1'b0;
    stage_rst = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nxt = PREP;
        frame_nxt = rw ? (READ_WRAP ? FR_A : FR_R) : FR_W;
      end
      // PREP doubles as the engine-reset pulse after a watchdog expiry
      PREP: begin
        stage_rst = 1'b1;
        state_nxt = wdog_q ? GAP : WR_BYTES;
      end
      WR_BYTES: begin
        wr_en = 1'b1;
        if (spi_done && last_wr) state_nxt = (frame == FR_R) ? TURN : GAP;
        else if (wdog_exp)       state_nxt = PREP;
      end
      TURN: begin
        flag = 1'b1;
        if (cnt == 8'(TURN_CYC - 1)) state_nxt = RD_BYTES;
      end
      RD_BYTES: begin
        rd_en = 1'b1;
        if (spi_done && byte_idx == 2'd2) state_nxt = GAP;
        else if (wdog_exp)                state_nxt = PREP;
      end
      GAP: if (cnt == 8'(GAP_CYC - 1)) begin
        state_nxt = DONE;
        if (!wdog_q && frame == FR_A) begin
          frame_nxt = FR_R;
          state_nxt = WR_BYTES;
        end else if (!wdog_q && frame == FR_R && READ_WRAP) begin
          frame_nxt = FR_C;
          state_nxt = WR_BYTES;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including a same-cycle spi_done or expiry
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      flag      = 1'b0;
      stage_rst = 1'b1;
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame    <= FR_W;
      addr_q   <= '0;
      wdata_q  <= '0;
      byte_idx <= '0;
      cnt      <= '0;
      acc      <= '0;
      wdog_q   <= 1'b0;
      tx_data  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      frame <= frame_nxt;

      if (state_nxt != state || byte_done) cnt <= '0;
      else                                 cnt <= cnt + 8'd1;

      if (state == IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end

      if (state == IDLE && req)   wdog_q <= 1'b0;
      else if (wdog_exp && !abort) wdog_q <= 1'b1;

      if (state_nxt != state && (state_nxt == WR_BYTES || state_nxt == RD_BYTES))
        byte_idx <= '0;
      else if (byte_done && !abort)
        byte_idx <= byte_idx + 2'd1;

      if (state_nxt == IDLE)
        tx_data <= '0;
      else if (state_nxt == WR_BYTES && state != WR_BYTES)
        tx_data <= frame_byte(frame_nxt, addr_q, wdata_q, 2'd0);
      else if (state == WR_BYTES && spi_done && !abort)
        tx_data <= frame_byte(frame, addr_q, wdata_q, byte_idx + 2'd1);

      if (state == RD_BYTES && spi_done && !abort) begin
        acc <= {acc[7:0], rx_data};
        if (byte_idx == 2'd2) rdata <= {acc, rx_data};
      end
    end
  end

endmodule

// File: tb/tb_afe_spi_reg_ctrl.sv
// tb/tb_afe_spi_reg_ctrl.sv - directed scoreboard bench with byte-engine and SPI slave model
module tb_afe_spi_reg_ctrl;

  localparam int GAP = 4;

  typedef struct {
    logic        err;
    logic [23:0] rdata;
    int          wr, rd, fl, sr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, req, rw, abort, stuck;
  logic [7:0]  addr;
  logic [23:0] wdata, slave_word;

  logic        busy0, ack0, err0, wr0, rd0, srst0, flag0;
  logic        busy1, ack1, err1, wr1, rd1, srst1, flag1;
  logic [23:0] rdata0, rdata1;
  logic [7:0]  tx0, tx1;

  logic        busy, ack, err, wr_en, rd_en, stage_rst, flag, spi_done;
  logic [23:0] rdata;
  logic [7:0]  tx_data, rx_data;
  logic [6:0]  ctl;

  afe_spi_reg_ctrl #(.READ_WRAP(1'b1)) u_wrap (
    .div_clk(clk), .rst_n(rst_n), .req(req & !sel), .rw(rw), .addr(addr), .wdata(wdata),
    .abort(abort & !sel), .busy(busy0), .ack(ack0), .err(err0), .rdata(rdata0),
    .wr_en(wr0), .rd_en(rd0), .stage_rst(srst0), .flag(flag0), .tx_data(tx0),
    .spi_done(spi_done & !sel), .rx_data(rx_data));

  afe_spi_reg_ctrl #(.READ_WRAP(1'b0)) u_nowrap (
    .div_clk(clk), .rst_n(rst_n), .req(req & sel), .rw(rw), .addr(addr), .wdata(wdata),
    .abort(abort & sel), .busy(busy1), .ack(ack1), .err(err1), .rdata(rdata1),
    .wr_en(wr1), .rd_en(rd1), .stage_rst(srst1), .flag(flag1), .tx_data(tx1),
    .spi_done(spi_done & sel), .rx_data(rx_data));

  assign busy      = sel ? busy1  : busy0;
  assign ack       = sel ? ack1   : ack0;
  assign err       = sel ? err1   : err0;
  assign wr_en     = sel ? wr1    : wr0;
  assign rd_en     = sel ? rd1    : rd0;
  assign stage_rst = sel ? srst1  : srst0;
  assign flag      = sel ? flag1  : flag0;
  assign rdata     = sel ? rdata1 : rdata0;
  assign tx_data   = sel ? tx1    : tx0;
  assign ctl       = {busy, ack, err, wr_en, rd_en, flag, stage_rst};

  // Byte engine: 16 cycles per byte, one extra setup cycle before the first read byte.
  int         bcnt, ridx;
  logic       first_rd;
  assign spi_done = (wr_en || rd_en) && !stuck && (bcnt == ((rd_en && first_rd) ? 16 : 15));

  always_comb begin
    case (ridx)
      0:       rx_data = slave_word[23:16];
      1:       rx_data = slave_word[15:8];
      default: rx_data = slave_word[7:0];
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt     <= 0;
      ridx     <= 0;
      first_rd <= 1'b1;
    end else begin
      bcnt     <= (!(wr_en || rd_en) || spi_done) ? 0 : bcnt + 1;
      first_rd <= !rd_en ? 1'b1 : (spi_done ? 1'b0 : first_rd);
      ridx     <= !rd_en ? 0 : (spi_done ? ridx + 1 : ridx);
    end
  end

  int         wr_cyc = 0, rd_cyc = 0, flag_cyc = 0, srst_cyc = 0, ack_cnt = 0, excl_bad = 0, run = 0;
  logic [7:0] mosi_log[$];
  int         runs[$];

  always @(negedge clk) begin
    if (wr_en)     wr_cyc++;
    if (rd_en)     rd_cyc++;
    if (flag)      flag_cyc++;
    if (stage_rst) srst_cyc++;
    if (ack)       ack_cnt++;
    if (int'(wr_en) + int'(rd_en) + int'(flag) + int'(stage_rst) > 1) excl_bad++;
    if (spi_done && wr_en) mosi_log.push_back(tx_data);
    if (busy && !(wr_en || rd_en || flag || stage_rst)) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  int         total = 0, bad = 0;
  int         s_wr, s_rd, s_fl, s_sr, s_mosi, s_runs, s_ack;
  exp_t       sb[$];
  logic [7:0] exp_mosi[$];
  int         exp_runs[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic e, input logic [23:0] rd, input int w, input int r,
                          input int f, input int s);
    exp_t x;
    x.err = e; x.rdata = rd; x.wr = w; x.rd = r; x.fl = f; x.sr = s;
    sb.push_back(x);
  endtask

  task automatic start_req(input logic s, input logic r, input logic [7:0] a, input logic [23:0] d);
    sel = s; rw = r; addr = a; wdata = d;
    s_wr = wr_cyc; s_rd = rd_cyc; s_fl = flag_cyc; s_sr = srst_cyc;
    s_mosi = mosi_log.size(); s_runs = runs.size(); s_ack = ack_cnt;
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (ack !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, " ack"}, 32'(ack), 32'd1);
    e = sb.pop_front();
    check({tag, " err"}, 32'(err), 32'(e.err));
    check({tag, " rdata"}, 32'(rdata), 32'(e.rdata));
    check({tag, " busy at ack"}, 32'(busy), 32'd1);
    tick(1);
    check({tag, " busy after ack"}, 32'(busy), 32'd0);
    tick(1);
    check({tag, " wr_en cycles"}, 32'(wr_cyc - s_wr), 32'(e.wr));
    check({tag, " rd_en cycles"}, 32'(rd_cyc - s_rd), 32'(e.rd));
    check({tag, " flag cycles"}, 32'(flag_cyc - s_fl), 32'(e.fl));
    check({tag, " stage_rst cycles"}, 32'(srst_cyc - s_sr), 32'(e.sr));
    check({tag, " mosi count"}, 32'(mosi_log.size() - s_mosi), 32'(exp_mosi.size()));
    foreach (exp_mosi[i])
      check($sformatf("%s mosi[%0d]", tag, i),
            (s_mosi + i < mosi_log.size()) ? 32'(mosi_log[s_mosi + i]) : 32'hx, 32'(exp_mosi[i]));
    check({tag, " idle runs"}, 32'(runs.size() - s_runs), 32'(exp_runs.size()));
    foreach (exp_runs[i])
      check($sformatf("%s run[%0d]", tag, i),
            (s_runs + i < runs.size()) ? 32'(runs[s_runs + i]) : 32'hx, 32'(exp_runs[i]));
    exp_mosi.delete();
    exp_runs.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; sel = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    abort = 1'b0; stuck = 1'b0; slave_word = '0;
    tick(2);
    check("reset ctl wrap", 32'(ctl), 32'd0);
    check("reset tx_data wrap", 32'(tx_data), 32'd0);
    check("reset rdata wrap", 32'(rdata), 32'd0);
    sel = 1'b1;
    #1;
    check("reset ctl nowrap", 32'(ctl), 32'd0);
    check("reset rdata nowrap", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // plain write
    push_exp(1'b0, 24'h0, 64, 0, 0, 1);
    exp_mosi = '{8'h01, 8'h12, 8'h34, 8'h56};
    exp_runs = '{GAP + 1};
    start_req(1'b0, 1'b0, 8'h01, 24'h123456);
    wait_ack("write");

    // wrapped read
    slave_word = 24'hABCDEF;
    push_exp(1'b0, 24'hABCDEF, 144, 49, 1, 1);
    exp_mosi = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_runs = '{GAP, GAP, GAP + 1};
    start_req(1'b0, 1'b1, 8'h2A, 24'h0);
    wait_ack("read wrap");

    // unwrapped read
    push_exp(1'b0, 24'hABCDEF, 16, 49, 1, 1);
    exp_mosi = '{8'h2A};
    exp_runs = '{GAP + 1};
    start_req(1'b1, 1'b1, 8'h2A, 24'h0);
    wait_ack("read nowrap");

    // requests while busy are dropped
    push_exp(1'b0, 24'hABCDEF, 64, 0, 0, 1);
    exp_mosi = '{8'h05, 8'hA5, 8'hA5, 8'hA5};
    exp_runs = '{GAP + 1};
    start_req(1'b0, 1'b0, 8'h05, 24'hA5A5A5);
    for (int k = 0; k < 3; k++) begin
      tick(15);
      addr = 8'h77; wdata = 24'h000000; rw = 1'b1; req = 1'b1;
      tick(1);
      req = 1'b0;
    end
    wait_ack("busy req");
    tick(100);
    check("busy req single ack", 32'(ack_cnt - s_ack), 32'd1);

    // engine never completes a byte
    stuck = 1'b1;
    slave_word = 24'h111111;
    push_exp(1'b1, 24'hABCDEF, 32, 0, 0, 2);
    exp_runs = '{GAP + 1};
    start_req(1'b0, 1'b1, 8'h2A, 24'h0);
    wait_ack("watchdog");
    stuck = 1'b0;

    // async reset in the middle of byte 2
    start_req(1'b0, 1'b0, 8'h10, 24'h445566);
    n = 0;
    while (mosi_log.size() == s_mosi && n < 500) begin
      tick(1);
      n++;
    end
    check("reset: first byte sent", 32'(mosi_log.size() - s_mosi), 32'd1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("mid reset ctl", 32'(ctl), 32'd0);
    check("mid reset tx_data", 32'(tx_data), 32'd0);
    check("mid reset rdata", 32'(rdata), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(50);
    check("mid reset no ack", 32'(ack_cnt - s_ack), 32'd0);
    push_exp(1'b0, 24'h0, 64, 0, 0, 1);
    exp_mosi = '{8'h10, 8'h44, 8'h55, 8'h66};
    exp_runs = '{GAP + 1};
    start_req(1'b0, 1'b0, 8'h10, 24'h445566);
    wait_ack("write after reset");

    // abort during the read bytes
    slave_word = 24'h5A5A5A;
    start_req(1'b0, 1'b1, 8'h2A, 24'h0);
    n = 0;
    while (rd_en !== 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    check("abort: reached read bytes", 32'(rd_en), 32'd1);
    tick(20);
    abort = 1'b1;
    #1;
    check("abort cycle enables", 32'({wr_en, rd_en, flag, stage_rst}), 32'b0001);
    tick(1);
    abort = 1'b0;
    check("after abort ctl", 32'(ctl), 32'd0);
    check("after abort tx_data", 32'(tx_data), 32'd0);
    check("after abort rdata", 32'(rdata), 32'd0);
    tick(60);
    check("abort no ack", 32'(ack_cnt - s_ack), 32'd0);
    push_exp(1'b0, 24'h5A5A5A, 144, 49, 1, 1);
    exp_mosi = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_runs = '{GAP, GAP, GAP + 1};
    start_req(1'b0, 1'b1, 8'h2A, 24'h0);
    wait_ack("read after abort");

    check("enables mutually exclusive", 32'(excl_bad), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
